// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM encoding,
// index-width helper and timeout counter width.
package wb_arb_defs;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

  localparam int TO_CNT_W = 8;

  // Width of a master index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; master is the opposite side.
interface wb_rr_arbiter_if #(
  parameter int MASTER_COUNT = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16
);
  logic [MASTER_COUNT-1:0]            m_cyc_i;
  logic [MASTER_COUNT-1:0]            m_stb_i;
  logic [MASTER_COUNT-1:0]            m_we_i;
  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i;
  logic [MASTER_COUNT-1:0]            m_ack_o;
  logic [DATA_WIDTH-1:0]              m_dat_o;
  logic                               s_cyc_o;
  logic                               s_stb_o;
  logic                               s_we_o;
  logic [DATA_WIDTH-1:0]              s_dat_o;
  logic [ADDR_WIDTH-1:0]              s_adr_o;
  logic                               s_ack_i;
  logic [DATA_WIDTH-1:0]              s_dat_i;
  logic [MASTER_COUNT-1:0]            grant_o;
  logic                               timeout_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_dat_i, m_adr_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_dat_o, s_adr_o,
           grant_o, timeout_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_dat_i, m_adr_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_dat_o, s_adr_o,
           grant_o, timeout_o
  );

endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester searching upward,
// modulo N, starting at ptr+1.
module wb_rr_pick
  import wb_arb_defs::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic [N-1:0]              gnt,
  output logic                      valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!valid && req[k] && (k == (int'(ptr) + off) % N)) begin
          gnt[k] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between MASTER_COUNT masters.
// Optional stalled-ack timeout with master masking: define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_defs::*;
#(
  parameter int MASTER_COUNT   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_rr_arbiter_if.slave       bus
);

  localparam int IW = idx_width(MASTER_COUNT);

  if (MASTER_COUNT < 2 || MASTER_COUNT > 8 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("wb_rr_arbiter: parameter out of legal range");
  end

  arb_state_e              state_q, state_d;
  logic [MASTER_COUNT-1:0] grant_q, grant_d;
  logic [IW-1:0]           ptr_q, ptr_d;

  logic [MASTER_COUNT-1:0] req;
  logic [MASTER_COUNT-1:0] pick_gnt;
  logic                    pick_valid;
  logic                    in_grant;
  logic [IW-1:0]           g_idx;
  logic                    g_cyc, g_stb, g_we;
  logic [DATA_WIDTH-1:0]   g_dat;
  logic [ADDR_WIDTH-1:0]   g_adr;
  logic                    s_stb;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0]     cnt_q, cnt_d;
  logic [MASTER_COUNT-1:0] mask_q, mask_d;
  logic                    stall;
  logic                    expire;

  assign req    = bus.m_cyc_i & ~mask_q;
  assign stall  = s_stb && !bus.s_ack_i;
  assign expire = stall && (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_o = expire;
`else
  assign req           = bus.m_cyc_i;
  assign bus.timeout_o = 1'b0;
`endif

  wb_rr_pick #(.N(MASTER_COUNT)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Decode the registered one-hot grant into an index and the granted master's bus.
  always_comb begin
    g_idx = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_dat = '0;
    g_adr = '0;
    for (int k = 0; k < MASTER_COUNT; k++) begin
      if (grant_q[k]) begin
        g_idx = IW'(k);
        g_cyc = bus.m_cyc_i[k];
        g_stb = bus.m_stb_i[k];
        g_we  = bus.m_we_i[k];
        g_dat = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        g_adr = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign in_grant    = (state_q == S_GRANT);
  assign s_stb       = in_grant && g_cyc && g_stb;
  assign bus.s_cyc_o = in_grant && g_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = in_grant && g_cyc && g_we;
  assign bus.s_dat_o = in_grant ? g_dat : '0;
  assign bus.s_adr_o = in_grant ? g_adr : '0;
  assign bus.m_ack_o = (in_grant && bus.s_ack_i) ? grant_q : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    mask_d  = mask_q & bus.m_cyc_i;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!g_cyc) begin
          state_d = S_IDLE;
          ptr_d   = g_idx;
          grant_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        // Forced release: the master stays masked until it drops cyc.
        else if (expire) begin
          state_d = S_IDLE;
          ptr_d   = g_idx;
          grant_d = '0;
          cnt_d   = '0;
          mask_d  = mask_d | grant_q;
        end else if (stall) begin
          cnt_d = cnt_q + 1'b1;
        end else if (bus.s_ack_i) begin
          cnt_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(MASTER_COUNT - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
`endif
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with a zero-wait memory slave;
// the timeout scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;
  import wb_arb_defs::*;

  localparam int MC = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.MASTER_COUNT(MC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_rr_arbiter #(
    .MASTER_COUNT  (MC),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [MC-1:0]    m_cyc, m_stb, m_we;
  logic [MC*DW-1:0] m_dat;
  logic [MC*AW-1:0] m_adr;
  logic             auto_ack, ack_inject;
  logic [DW-1:0]    mem [16];

  assign bus.m_cyc_i = m_cyc;
  assign bus.m_stb_i = m_stb;
  assign bus.m_we_i  = m_we;
  assign bus.m_dat_i = m_dat;
  assign bus.m_adr_i = m_adr;
  assign bus.s_ack_i = (auto_ack & bus.s_cyc_o & bus.s_stb_o) | ack_inject;
  assign bus.s_dat_i = mem[bus.s_adr_o[3:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.s_cyc_o && bus.s_stb_o && bus.s_we_o && bus.s_ack_i) begin
      mem[bus.s_adr_o[3:0]] <= bus.s_dat_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_dat = '0; m_adr = '0;
    auto_ack = 1'b1; ack_inject = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("rst_sstb", 32'(bus.s_stb_o), 32'h0);
    chk("rst_mack", 32'(bus.m_ack_o), 32'h0);
    chk("rst_tmo", 32'(bus.timeout_o), 32'h0);
    $display("reset done");

    // Single master: write then read back
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1*AW +: AW] = 16'd3; m_dat[1*DW +: DW] = 16'h1111;
    #1;
    chk("t1_latency_scyc", 32'(bus.s_cyc_o), 32'h0);
    tick();
    chk("t1_scyc", 32'(bus.s_cyc_o), 32'h1);
    chk("t1_grant", 32'(bus.grant_o), 32'h2);
    chk("t1_adr", 32'(bus.s_adr_o), 32'h3);
    chk("t1_we", 32'(bus.s_we_o), 32'h1);
    chk("t1_sdat", 32'(bus.s_dat_o), 32'h1111);
    chk("t1_wr_ack", 32'(bus.m_ack_o), 32'h2);
    $display("t1 write m1 adr=3 dat=1111 ack=%b", bus.m_ack_o);
    tick();
    m_we[1] = 1'b0;
    #1;
    chk("t1_rd_ack", 32'(bus.m_ack_o), 32'h2);
    chk("t1_rd_dat", 32'(bus.m_dat_o), 32'h1111);
    $display("t1 read m1 adr=3 dat=%h ack=%b", bus.m_dat_o, bus.m_ack_o);
    tick();
    m_cyc = '0; m_stb = '0;
    #1;
    chk("t1_drop_scyc", 32'(bus.s_cyc_o), 32'h0);
    tick();
    chk("t1_release_grant", 32'(bus.grant_o), 32'h0);

    // Four simultaneous requesters after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cyc = 4'hf; m_stb = 4'hf; m_we = '0;
    #1;
    chk("t2_idle_grant", 32'(bus.grant_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t2_grant%0d", i), 32'(bus.grant_o), 32'd1 << order[i]);
      tick();
      chk($sformatf("t2_hold%0d", i), 32'(bus.grant_o), 32'd1 << order[i]);
      $display("t2 tenure %0d grant=%b", i, bus.grant_o);
      m_cyc[order[i]] = 1'b0; m_stb[order[i]] = 1'b0;
      tick();
      chk($sformatf("t2_dead%0d", i), 32'(bus.grant_o), 32'h0);
      if (i == 0) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      end
    end

    // No preemption of master 2 by master 0
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    m_adr[2*AW +: AW] = 16'd5; m_dat[2*DW +: DW] = 16'h2222;
    tick();
    chk("t3_grant2", 32'(bus.grant_o), 32'h4);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    chk("t3_nopreempt", 32'(bus.grant_o), 32'h4);
    chk("t3_ack_only2", 32'(bus.m_ack_o), 32'h4);
    tick();
    chk("t3_still2", 32'(bus.grant_o), 32'h4);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
    tick();
    chk("t3_dead", 32'(bus.grant_o), 32'h0);
    tick();
    chk("t3_grant0", 32'(bus.grant_o), 32'h1);
    $display("t3 after dead cycle grant=%b", bus.grant_o);
    m_cyc = '0; m_stb = '0;
    tick();

    // Slave ack while idle is ignored
    ack_inject = 1'b1;
    #1;
    chk("t4_mack", 32'(bus.m_ack_o), 32'h0);
    chk("t4_scyc", 32'(bus.s_cyc_o), 32'h0);
    tick();
    chk("t4_grant", 32'(bus.grant_o), 32'h0);
    chk("t4_mack2", 32'(bus.m_ack_o), 32'h0);
    $display("t4 idle ack injected m_ack=%b", bus.m_ack_o);
    ack_inject = 1'b0;

    // Reset mid-transfer
    auto_ack = 1'b0;
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    tick();
    chk("t5_grant3", 32'(bus.grant_o), 32'h8);
    chk("t5_sstb", 32'(bus.s_stb_o), 32'h1);
    rst = 1'b1;
    m_cyc = 4'b1001; m_stb = 4'b1001;
    tick();
    ack_inject = 1'b1;
    #1;
    chk("t5_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("t5_sstb0", 32'(bus.s_stb_o), 32'h0);
    chk("t5_grant0", 32'(bus.grant_o), 32'h0);
    chk("t5_mack", 32'(bus.m_ack_o), 32'h0);
    chk("t5_tmo", 32'(bus.timeout_o), 32'h0);
    ack_inject = 1'b0;
    auto_ack = 1'b1;
    rst = 1'b0;
    tick();
    chk("t5_first_m0", 32'(bus.grant_o), 32'h1);
    $display("t5 after reset grant=%b", bus.grant_o);
    m_cyc = '0; m_stb = '0;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: master 1 times out and is masked
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_ack = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    chk("t6_grant1", 32'(bus.grant_o), 32'h2);
    chk("t6_tmo_s1", 32'(bus.timeout_o), 32'h0);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("t6_tmo_s%0d", i), 32'(bus.timeout_o), (i == 8) ? 32'h1 : 32'h0);
    end
    chk("t6_grant_s8", 32'(bus.grant_o), 32'h2);
    tick();
    chk("t6_tmo_clear", 32'(bus.timeout_o), 32'h0);
    chk("t6_released", 32'(bus.grant_o), 32'h0);
    auto_ack = 1'b1;
    tick();
    chk("t6_grant2", 32'(bus.grant_o), 32'h4);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
    chk("t6_dead", 32'(bus.grant_o), 32'h0);
    tick();
    chk("t6_masked", 32'(bus.grant_o), 32'h0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    chk("t6_regrant1", 32'(bus.grant_o), 32'h2);
    $display("t6 timeout sequence grant=%b", bus.grant_o);
    m_cyc = '0; m_stb = '0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
